// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes a raw, bouncing pin, debounces it with a
// stability counter, and emits level, press/release/long-press pulses and a press count.
module button_debouncer #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 12000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnIn,
    output logic       pressed,
    output logic       pressEvent,
    output logic       releaseEvent,
    output logic       longPress,
    output logic [7:0] pressCount
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LP_MAX   = LW'(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_LAST  = LW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt, cnt_n;
    logic [LW-1:0]          lp_cnt, lp_n;
    logic                   s;
    logic                   lp_inc;
    logic                   pressed_n, press_ev_n, release_ev_n, long_ev_n;
    logic [7:0]             count_n;

    // sync[0] is the first flop; the pipeline rests at the released pin level
    always_ff @(posedge clk) begin
        if (rst) sync <= {SYNC_STAGES{ACTIVE_LOW}};
        else     sync <= {sync[SYNC_STAGES-2:0], btnIn};
    end

    assign s = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lp_n         = lp_cnt;
        lp_inc       = 1'b0;
        pressed_n    = pressed;
        press_ev_n   = 1'b0;
        release_ev_n = 1'b0;
        long_ev_n    = 1'b0;
        count_n      = pressCount;
        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_PEND;
                    cnt_n   = CW'(1);
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n    = HELD;
                    cnt_n      = '0;
                    pressed_n  = 1'b1;
                    press_ev_n = 1'b1;
                    count_n    = pressCount + 8'd1;
                    lp_n       = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_n = RELEASE_PEND;
                    cnt_n   = CW'(1);
                end else begin
                    lp_inc = 1'b1;
                end
            end
            RELEASE_PEND: begin
                // hold time keeps accumulating across a tentative release
                lp_inc = 1'b1;
                if (s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n      = IDLE;
                    cnt_n        = '0;
                    pressed_n    = 1'b0;
                    release_ev_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (lp_inc && lp_cnt != LP_MAX) begin
            lp_n      = lp_cnt + LW'(1);
            long_ev_n = (lp_cnt == LP_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lp_cnt       <= '0;
            pressed      <= 1'b0;
            pressEvent   <= 1'b0;
            releaseEvent <= 1'b0;
            longPress    <= 1'b0;
            pressCount   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            lp_cnt       <= lp_n;
            pressed      <= pressed_n;
            pressEvent   <= press_ev_n;
            releaseEvent <= release_ev_n;
            longPress    <= long_ev_n;
            pressCount   <= count_n;
        end
    end
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: scenario tasks compare DUT outputs every cycle against
// a run-length reference model of the debounce / long-press rules.
module tb_button_debouncer;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LP   = 16;
    localparam bit AL   = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       btnIn;
    logic       pressed, pressEvent, releaseEvent, longPress;
    logic [7:0] pressCount;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btnIn(btnIn),
        .pressed(pressed),
        .pressEvent(pressEvent),
        .releaseEvent(releaseEvent),
        .longPress(longPress),
        .pressCount(pressCount)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: delay line of pressed-levels, committed level, run length of
    // disagreeing samples, and time held since the press was committed.
    bit         mq[$];
    bit         m_lvl;
    int         m_run;
    int         m_held;
    logic [7:0] m_cnt;
    bit         m_pe, m_re, m_lp;

    logic [11:0] obs;
    assign obs = {pressed, pressEvent, releaseEvent, longPress, pressCount};

    function automatic logic [11:0] expv();
        return {m_lvl, m_pe, m_re, m_lp, m_cnt};
    endfunction

    task automatic step(input bit b, input bit r);
        bit s_in;
        btnIn = b;
        rst   = r;
        @(posedge clk);
        m_pe = 1'b0;
        m_re = 1'b0;
        m_lp = 1'b0;
        if (r) begin
            mq.delete();
            repeat (SYNC) mq.push_back(1'b0);
            m_lvl  = 1'b0;
            m_run  = 0;
            m_held = 0;
            m_cnt  = 8'd0;
        end else begin
            s_in = mq.pop_front();
            mq.push_back(AL ? ~b : b);
            // the first sample of a tentative release does not add hold time
            if (m_lvl && !(s_in == 1'b0 && m_run == 0) && m_held < LP) begin
                m_held++;
                if (m_held == LP) m_lp = 1'b1;
            end
            if (s_in != m_lvl) m_run++;
            else               m_run = 0;
            if (m_run == DEB) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    m_pe   = 1'b1;
                    m_cnt  = m_cnt + 8'd1;
                    m_held = 0;
                end else begin
                    m_re = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b1);
        total++;
        if (obs !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got=%h exp=000", obs);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            total++;
            if (obs !== expv() || obs !== 12'h000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
    endtask

    task automatic test_press_latency();
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL press_model cyc=%0d got=%h exp=%h", k, obs, expv());
            end
            total++;
            if (pressEvent !== (k == 6) || pressed !== (k >= 6)) begin
                bad++;
                $display("FAIL press_latency cyc=%0d got pe=%b pr=%b", k, pressEvent, pressed);
            end
        end
        total++;
        if (pressCount !== 8'd1) begin
            bad++;
            $display("FAIL press_count got=%0d exp=1", pressCount);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL press_release cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
    endtask

    task automatic test_glitch();
        int pe_seen = 0;
        for (int k = 0; k < 15; k++) begin
            step(k < 3 ? 1'b0 : 1'b1, 1'b0);
            total++;
            if (obs !== expv() || pressEvent !== 1'b0 || pressed !== 1'b0) begin
                bad++;
                $display("FAIL glitch3 cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
        for (int k = 1; k <= 16; k++) begin
            step(k <= 4 ? 1'b0 : 1'b1, 1'b0);
            if (pressEvent === 1'b1) pe_seen++;
            total++;
            if (obs !== expv() || pressEvent !== (k == 6)) begin
                bad++;
                $display("FAIL glitch4 cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
        total++;
        if (pe_seen !== 1) begin
            bad++;
            $display("FAIL glitch4_count got=%0d exp=1", pe_seen);
        end
    endtask

    task automatic test_bounce_release();
        bit pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int re_seen = 0;
        int pe_seen = 0;
        int re_pos  = -1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL bounce_press cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
        for (int k = 0; k < 8 + 12; k++) begin
            step(k < 8 ? pat[k] : 1'b1, 1'b0);
            if (releaseEvent === 1'b1) begin
                re_seen++;
                re_pos = k - 8 + 1;
            end
            if (pressEvent === 1'b1) pe_seen++;
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL bounce_model cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
        total++;
        if (re_seen !== 1 || re_pos !== 6 || pe_seen !== 0) begin
            bad++;
            $display("FAIL bounce_release got re=%0d pos=%0d pe=%0d exp re=1 pos=6 pe=0",
                     re_seen, re_pos, pe_seen);
        end
    endtask

    task automatic test_long_press();
        for (int round = 0; round < 2; round++) begin
            int pe_pos = -1;
            int lp_pos = -1;
            int lp_seen = 0;
            for (int k = 1; k <= 40; k++) begin
                step(1'b0, 1'b0);
                if (pressEvent === 1'b1) pe_pos = k;
                if (longPress === 1'b1) begin
                    lp_seen++;
                    lp_pos = k;
                end
                total++;
                if (obs !== expv()) begin
                    bad++;
                    $display("FAIL long_model r=%0d cyc=%0d got=%h exp=%h", round, k, obs, expv());
                end
            end
            total++;
            if (lp_seen !== 1 || lp_pos !== pe_pos + LP) begin
                bad++;
                $display("FAIL long_press r=%0d got n=%0d pos=%0d exp n=1 pos=%0d",
                         round, lp_seen, lp_pos, pe_pos + LP);
            end
            for (int k = 0; k < 10; k++) begin
                step(1'b1, 1'b0);
                total++;
                if (obs !== expv()) begin
                    bad++;
                    $display("FAIL long_release r=%0d cyc=%0d got=%h exp=%h", round, k, obs, expv());
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 12; k++) begin
                step(k < 6 ? 1'b0 : 1'b1, 1'b0);
                total++;
                if (obs !== expv()) begin
                    bad++;
                    $display("FAIL wrap_model i=%0d cyc=%0d got=%h exp=%h", i, k, obs, expv());
                end
                if (pressEvent === 1'b1) begin
                    n++;
                    if (n == 255 || n == 256) begin
                        total++;
                        if (pressCount !== 8'(n)) begin
                            bad++;
                            $display("FAIL wrap_count n=%0d got=%0d exp=%0d", n, pressCount, n % 256);
                        end
                    end
                end
            end
        end
        total++;
        if (n !== 256) begin
            bad++;
            $display("FAIL wrap_events got=%0d exp=256", n);
        end
    endtask

    task automatic test_reset_held();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        total++;
        if (pressed !== 1'b1) begin
            bad++;
            $display("FAIL rsthold_pre got=%b exp=1", pressed);
        end
        step(1'b0, 1'b1);
        total++;
        if (pressed !== 1'b0 || releaseEvent !== 1'b0 || obs !== expv()) begin
            bad++;
            $display("FAIL rsthold_reset got=%h exp=%h", obs, expv());
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs !== expv() || pressEvent !== (k == 6) || releaseEvent !== 1'b0) begin
                bad++;
                $display("FAIL rsthold_press cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit b = 1'b1;
        int run = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run == 0) begin
                b   = ~b;
                run = (($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 7));
            end
            run--;
            step(b, $urandom_range(0, 299) == 0);
            total++;
            if (obs !== expv() || (pressEvent === 1'b1 && releaseEvent === 1'b1)) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, obs, expv());
            end
        end
    endtask

    initial begin
        btnIn = 1'b1;
        rst   = 1'b1;
        test_reset();
        test_press_latency();
        test_glitch();
        test_bounce_release();
        test_long_press();
        test_wrap();
        test_reset_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the board's LED/blinky output logic: conditions a raw, asynchronous, bouncing push-button pin into clean clk-domain signals.
- Synchronizes the pin and debounces it with a stability counter.
- Emits a debounced level plus one-cycle press, release and long-press events, and keeps a wrapping press counter for status/LED logic.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (>=2).
- DEBOUNCE_CYCLES, 12000, consecutive stable synchronized cycles needed to commit a level change (1 ms at 12 MHz; >=2).
- LONG_PRESS_CYCLES, 12000000, cycles held after pressEvent before longPress fires (>=1).
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock (12 MHz on board)
- rst  input  1  synchronous, active-high reset
- btnIn  input  1  raw asynchronous button pin
- pressed  output  1  debounced level, 1 = held
- pressEvent  output  1  one-cycle pulse on committed press
- releaseEvent  output  1  one-cycle pulse on committed release
- longPress  output  1  one-cycle pulse, at most once per press
- pressCount  output  8  number of committed presses, mod 256

Behaviour:
- Reset values: all outputs 0; synchronizer flops at the released (inactive) level; debounce and long-press counters 0; FSM in IDLE.
- Reset is synchronous and overrides everything.
  - Reset mid-debounce or mid-press discards all progress.
  - No releaseEvent is generated by reset.
- Polarity: s = synchronizer output XOR ACTIVE_LOW, so s = 1 means pressed.
- FSM states: IDLE, PRESS_PEND, HELD, RELEASE_PEND. The debounce counter cnt is sized $clog2(DEBOUNCE_CYCLES+1).
- IDLE:
  - s = 1 -> PRESS_PEND, cnt = 1.
- PRESS_PEND:
  - s = 0 -> IDLE, cnt = 0 (glitch rejected; no event).
  - s = 1 and cnt < DEBOUNCE_CYCLES-1 -> cnt++.
  - s = 1 and cnt == DEBOUNCE_CYCLES-1 -> HELD; pressed = 1; pressEvent = 1 for one cycle; pressCount++; long-press counter cleared.
- HELD:
  - s = 0 -> RELEASE_PEND, cnt = 1.
  - Otherwise the long-press counter increments and saturates.
  - longPress pulses once, in the cycle the counter reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES cycles after the pressEvent cycle.
- RELEASE_PEND:
  - Mirror of PRESS_PEND.
  - s = 1 -> back to HELD, cnt = 0; the long-press counter keeps its value and keeps counting.
  - On commit: IDLE, pressed = 0, releaseEvent = 1 for one cycle.
  - longPress may still fire in RELEASE_PEND if the threshold is reached there.
- Latency: a raw pin change held stable reaches pressEvent/releaseEvent high exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first clk edge that samples the new level.
- A bounce shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- A bounce exactly DEBOUNCE_CYCLES long commits.
- pressCount wraps 255 -> 0 silently.
- pressEvent and releaseEvent are never high in the same cycle, and never on consecutive cycles (minimum spacing DEBOUNCE_CYCLES).
- All outputs are registered; there is no combinational path from btnIn.
- Button held through reset: after reset deasserts, the press is detected as new and pressEvent fires after the normal latency.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1):
- Reset, btnIn=1 for 20 cycles -> pressed=0, all events 0, pressCount=0 throughout.
- Drive btnIn=0 at edge 0 and hold -> pressEvent high only in cycle 6; pressed=1 from cycle 6; pressCount=1.
- While idle, pulse btnIn=0 for 3 cycles, then 1 -> no events, pressed stays 0. A pulse of exactly 4 cycles -> pressEvent fires.
- Hold the press, then release with 2-cycle bounces (1,0,1,0,1 held) -> exactly one releaseEvent, 6 cycles after the final stable edge; no spurious pressEvent.
- Hold the press for 30 cycles -> longPress is a single pulse exactly 16 cycles after pressEvent, with no repeat. Release then re-press -> a new longPress is possible.
- 256 clean press/release cycles -> pressCount reads 0 after the 256th pressEvent.
- Assert rst for 1 cycle while in HELD -> pressed=0 next cycle, no releaseEvent. With btnIn still low, pressEvent fires 6 cycles after rst deasserts.
